// File: rtl/dot_text_sequencer.sv
// dot_text_sequencer: accepts hex digit codes and writes their 5x7 glyphs
// column by column to a dot-matrix driver, paced by a free-running scan tick.
// Optional feature macro: DOT_SCROLL_EN (scrolls each new glyph in from the
// right through a 5-column shadow of the displayed image).
module dot_text_sequencer #(
  parameter int SCAN_DIV = 1000,
  parameter int DWELL    = 50000,
  parameter int STEP_DIV = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [3:0] char_code,
  output logic       char_ready,
  output logic       busy,
  output logic       drv_enable,
  output logic       drv_write,
  output logic [4:0] drv_col_addr,
  output logic [6:0] drv_row
);

  localparam int PRE_W   = $clog2(SCAN_DIV);
  // One wait counter serves both the dwell and the scroll-step pauses.
  localparam int CNT_MAX = (DWELL > STEP_DIV) ? DWELL : STEP_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef DOT_SCROLL_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DWELL, S_STEP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DWELL} state_t;
`endif

  state_t             state, state_next;
  logic [PRE_W-1:0]   pre;
  logic [2:0]         col, col_next;
  logic [3:0]         code, code_next;
  logic [CNT_W-1:0]   wait_cnt, cnt_next;
  logic [6:0]         row_data;

`ifdef DOT_SCROLL_EN
  logic [2:0]         step, step_next;
  logic [4:0][6:0]    shadow, shadow_next;
`endif

  // Hex font: glyph packed as {col4, col3, col2, col1, col0}, bit0 = top row.
  function automatic logic [6:0] font_col(input logic [3:0] c, input logic [2:0] k);
    logic [34:0] g;
    g = '0;
    case (c)
      4'h0: g = {7'h3E, 7'h45, 7'h49, 7'h51, 7'h3E};
      4'h1: g = {7'h00, 7'h40, 7'h7F, 7'h42, 7'h00};
      4'h2: g = {7'h46, 7'h49, 7'h51, 7'h61, 7'h42};
      4'h3: g = {7'h31, 7'h4B, 7'h45, 7'h41, 7'h21};
      4'h4: g = {7'h10, 7'h7F, 7'h12, 7'h14, 7'h18};
      4'h5: g = {7'h39, 7'h45, 7'h45, 7'h45, 7'h27};
      4'h6: g = {7'h30, 7'h49, 7'h49, 7'h4A, 7'h3C};
      4'h7: g = {7'h03, 7'h05, 7'h09, 7'h71, 7'h01};
      4'h8: g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      4'h9: g = {7'h1E, 7'h29, 7'h49, 7'h49, 7'h06};
      4'hA: g = {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
      4'hB: g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h7F};
      4'hC: g = {7'h22, 7'h41, 7'h41, 7'h41, 7'h3E};
      4'hD: g = {7'h1C, 7'h22, 7'h41, 7'h41, 7'h7F};
      4'hE: g = {7'h41, 7'h49, 7'h49, 7'h49, 7'h7F};
      4'hF: g = {7'h01, 7'h09, 7'h09, 7'h09, 7'h7F};
    endcase
    return g[7*k +: 7];
  endfunction

  // The scan tick runs regardless of state; reset holds the prescaler at 0 so
  // the tick stays low while reset is asserted.
  assign drv_enable = (pre == PRE_W'(SCAN_DIV - 1));
  assign char_ready = (state == S_IDLE) && !reset;
  assign busy       = (state != S_IDLE);

`ifdef DOT_SCROLL_EN
  assign row_data = shadow[col];
`else
  assign row_data = font_col(code, col);
`endif

  // Free-running prescaler producing the drv_enable tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre <= '0;
    else if (drv_enable) pre <= '0;
    else pre <= pre + 1'b1;
  end

  // State and datapath registers; reset discards any in-flight glyph.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      col      <= '0;
      code     <= '0;
      wait_cnt <= '0;
`ifdef DOT_SCROLL_EN
      step     <= '0;
      shadow   <= '0;
`endif
    end else begin
      state    <= state_next;
      col      <= col_next;
      code     <= code_next;
      wait_cnt <= cnt_next;
`ifdef DOT_SCROLL_EN
      step     <= step_next;
      shadow   <= shadow_next;
`endif
    end
  end

  // Next-state logic and driver strobes; writes only ever happen on a tick.
  always_comb begin
    state_next   = state;
    col_next     = col;
    code_next    = code;
    cnt_next     = wait_cnt;
    drv_write    = 1'b0;
    drv_col_addr = '0;
    drv_row      = '0;
`ifdef DOT_SCROLL_EN
    step_next    = step;
    shadow_next  = shadow;
`endif
    case (state)
      S_IDLE: begin
        if (char_valid && char_ready) begin
          state_next = S_WRITE;
          col_next   = '0;
          code_next  = char_code;
          cnt_next   = '0;
`ifdef DOT_SCROLL_EN
          step_next   = 3'd1;
          shadow_next = {font_col(char_code, 3'd0), shadow[4:1]};
`endif
        end
      end
      S_WRITE: begin
        if (drv_enable) begin
          drv_write    = 1'b1;
          drv_col_addr = {2'b00, col};
          drv_row      = row_data;
          if (col == 3'd4) begin
            col_next = '0;
`ifdef DOT_SCROLL_EN
            if (step != 3'd5) begin
              state_next = S_STEP;
              cnt_next   = '0;
            end else
`endif
            begin
              // The write cycle itself is the reference point: IDLE is
              // reached exactly DWELL cycles after the last column write.
              state_next = (DWELL == 1) ? S_IDLE : S_DWELL;
              cnt_next   = (DWELL == 1) ? '0 : CNT_W'(1);
            end
          end else begin
            col_next = col + 3'd1;
          end
        end
      end
      S_DWELL: begin
        if (wait_cnt >= CNT_W'(DWELL - 1)) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = wait_cnt + 1'b1;
        end
      end
`ifdef DOT_SCROLL_EN
      S_STEP: begin
        if (wait_cnt >= CNT_W'(STEP_DIV - 1)) begin
          state_next  = S_WRITE;
          cnt_next    = '0;
          col_next    = '0;
          step_next   = step + 3'd1;
          shadow_next = {font_col(code, step), shadow[4:1]};
        end else begin
          cnt_next = wait_cnt + 1'b1;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/dot_text_sequencer.md
DOT_TEXT_SEQUENCER -- requirements
Module: dot_text_sequencer

Interface
REQ-001 SHALL provide parameter: SCAN_DIV, 1000, clk cycles per drv_enable pulse (>=2).
REQ-002 SHALL provide parameter: DWELL, 50000, clk cycles a completed glyph is held before the next request is accepted (>=1).
REQ-003 SHALL provide parameter: STEP_DIV, 20000, clk cycles between scroll steps (used only with DOT_SCROLL_EN).
REQ-004 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: char_valid  in  1  requester has a glyph code.
REQ-007 SHALL have port: char_code  in  4  hex digit 0x0-0xF to display.
REQ-008 SHALL have port: char_ready  out  1  sequencer accepts a code this cycle.
REQ-009 SHALL have port: busy  out  1  request in progress (not IDLE).
REQ-010 SHALL have port: drv_enable  out  1  one-cycle scan tick to the dot-matrix driver.
REQ-011 SHALL have port: drv_write  out  1  driver column-write strobe.
REQ-012 SHALL have port: drv_col_addr  out  5  driver column index 0-4 (0 = leftmost).
REQ-013 SHALL have port: drv_row  out  7  column data, bit0 = top row, 1 = lit.

Function
REQ-014 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; drv_enable SHALL be 1 exactly in cycles where the count equals SCAN_DIV-1, free-running in every state.
REQ-015 drv_write SHALL be asserted only in cycles where drv_enable=1; drv_col_addr/drv_row SHALL be valid in those cycles.
REQ-016 Internal font ROM SHALL hold 16 glyphs x 5 columns x 7 bits per the team hex font table; glyph 0x0 = 3E,51,49,45,3E; glyph 0x1 = 00,42,7F,40,00 (columns 0-4, hex).
REQ-017 FSM states SHALL be IDLE, WRITE, DWELL (plus STEP with DOT_SCROLL_EN).
REQ-018 char_ready SHALL equal 1 only in IDLE; busy SHALL equal NOT char_ready.
REQ-019 Transfer SHALL occur when char_valid & char_ready; code latched that edge; next state WRITE, column index 0.
REQ-020 WRITE: on each drv_enable tick SHALL emit drv_write with current column index and glyph column, then increment; after column 4 is written SHALL go to DWELL.
REQ-021 DWELL: SHALL count DWELL cycles from the cycle after the column-4 write, then go to IDLE.
REQ-022 char_valid while busy SHALL be ignored with no side effect; requester holds it.
REQ-023 Transfer cycle coinciding with a drv_enable tick SHALL NOT write that tick; first write occurs at the next tick.
REQ-024 Dwell and step counters SHALL be wide enough for their parameters and SHALL NOT wrap mid-count.

Reset
REQ-025 While reset=1: state IDLE, prescaler 0, counters 0, latched code 0, scroll shadow all 0.
REQ-026 Reset outputs SHALL be: char_ready=1 only after reset deasserts (0 while asserted), busy=0, drv_enable=0, drv_write=0, drv_col_addr=0, drv_row=0.
REQ-027 Reset mid-request SHALL discard the in-flight glyph; no further writes for it.

Configuration
REQ-028 Macro DOT_SCROLL_EN SHALL compile in scrolling transitions.
REQ-029 Without DOT_SCROLL_EN: each glyph written directly per REQ-020.
REQ-030 With DOT_SCROLL_EN: a 5-column shadow of the displayed image SHALL be kept; after transfer, 5 scroll steps occur; step k (1-5) shifts shadow left one column, appends new glyph column k-1 at column 4, writes all 5 shadow columns (addr 0-4) on 5 consecutive drv_enable ticks, then waits STEP_DIV cycles in STEP; after step 5 write completes, DWELL per REQ-021.

Verification
REQ-031 SCAN_DIV=4, DWELL=10, no macro; reset release, code 0x1 valid -> five writes addr 0..4 rows 00,42,7F,40,00 each on a drv_enable tick 4 cycles apart; char_ready=1 again exactly 10 cycles after last write.
REQ-032 Code 0x0 accepted, second code 0x1 held valid throughout -> 0x1 not accepted until IDLE; then its five writes follow; no write of 0x1 during 0x0 dwell.
REQ-033 Transfer on a drv_enable-tick cycle -> no write that tick; addr 0 written at next tick (4 cycles later).
REQ-034 Reset asserted after addr 2 write -> outputs at reset values immediately (async), no addr 3/4 write; after release char_ready=1, prescaler restarts from 0.
REQ-035 DOT_SCROLL_EN, SCAN_DIV=4, STEP_DIV=8: from blank, code 0x1 -> step 1 writes 00,00,00,00,00; step 5 writes 00,42,7F,40,00; 25 writes total, STEP gaps of 8 cycles.
REQ-036 Free-running check: 100 cycles idle, SCAN_DIV=4 -> drv_enable pulses exactly every 4th cycle, drv_write never asserted.
